seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter TICK_MAX, default 49999: prescaler terminal count; each digit is shown for TICK_MAX+1 clk cycles.
REQ-002 Parameter DIV_W, default 16: prescaler width; SHALL satisfy 2^DIV_W > TICK_MAX.
REQ-003 Port clk  input  1: single clock; all state changes on posedge clk.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port load_valid  input  1: load_value is offered this cycle.
REQ-006 Port load_value  input  16: four hex nibbles; nibble k drives digit k, digit 0 being least significant.
REQ-007 Port load_ready  output  1: the block can accept a load this cycle.
REQ-008 Port blank  input  1: forces all anodes off while high.
REQ-009 Port digit_data  output  4: nibble for the downstream 4-to-8 segment decoder.
REQ-010 Port anode_n  output  4: active-low digit enables; bit k selects digit k.
REQ-011 Port frame_done  output  1: one-cycle pulse at each 4-digit frame wrap.

Function
REQ-012 Prescaler SHALL count 0..TICK_MAX, then return to 0; tick is asserted in the cycle where prescaler == TICK_MAX.
REQ-013 On tick, the 2-bit digit index idx SHALL advance modulo 4 (3 -> 0 wraps).
REQ-014 A load SHALL be accepted when load_valid && load_ready; load_value is captured into pend_reg, pending is set, and load_ready is low from the next cycle.
REQ-015 On a tick with idx == 3 and pending set, display_reg SHALL take pend_reg and pending SHALL clear, so the shown value changes only at frame boundaries.
REQ-016 frame_done SHALL pulse for exactly one cycle on every tick with idx == 3, whether or not an update occurs.
REQ-017 If a load is accepted in the same cycle as a wrap tick, it SHALL go to pending and apply at the following wrap; it SHALL NOT bypass to display_reg.
REQ-018 load_valid while load_ready is low SHALL be ignored and SHALL NOT be buffered.
REQ-019 digit_data and anode_n SHALL be registered with one cycle latency from idx and display_reg: digit_data = display_reg[4*idx+3:4*idx]; anode_n = all ones except bit idx low.
REQ-020 digit_data and anode_n SHALL change on the same posedge; the downstream decoder samples on negedge, half a cycle later.
REQ-021 blank high SHALL drive anode_n = 4'b1111 one cycle later; prescaler, idx, loads and digit_data continue unaffected.

Reset
REQ-022 With rst high at posedge, the following SHALL hold on the next cycle: prescaler=0, idx=0, display_reg=0, pend_reg=0, pending=0, load_ready=1, digit_data=0, anode_n=4'b1110, frame_done=0.
REQ-023 Reset mid-frame or with pending set SHALL discard the pending value; reset has priority over load and tick in the same cycle.

Configuration
REQ-024 Macro SEVEN_SEG_SCAN_LZB_EN enables leading-zero blanking.
REQ-025 With SEVEN_SEG_SCAN_LZB_EN defined: for a digit k>0 whose nibble and all higher nibbles of display_reg are zero, that digit's anode_n bit SHALL stay high in its slot; digit 0 always lights.
REQ-026 Without SEVEN_SEG_SCAN_LZB_EN: all four digits light in their slots; no blanking logic is synthesised.

Verification (TICK_MAX=3)
REQ-027 After reset, release rst -> anode_n sequence 1110,1101,1011,0111, repeating, each held 4 cycles; frame_done pulses every 16 cycles.
REQ-028 Load 16'h1A3F mid-frame -> load_ready low until the next wrap; then digits show F,3,A,1 in order 0..3; an earlier frame still shows 0,0,0,0.
REQ-029 Second load_valid while load_ready is low, with value 16'h5555 -> ignored; display shows the first value only.
REQ-030 Load on the exact wrap-tick cycle -> value appears one full frame later (16 cycles), not immediately.
REQ-031 Assert rst with pending 16'hBEEF -> next cycle anode_n=1110, digit_data=0, load_ready=1; BEEF is never displayed.
REQ-032 With SEVEN_SEG_SCAN_LZB_EN, load 16'h0042 -> anodes 2 and 3 stay off and digits 0 and 1 light; load 16'h0000 -> only digit 0 lights, showing 0; blank=1 -> anode_n=1111 throughout.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit multiplexed display scanner with frame-aligned loads; SEVEN_SEG_SCAN_LZB_EN enables leading-zero blanking
module seven_seg_scan #(
  parameter int TICK_MAX = 49999,
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_value,
  output logic        load_ready,
  input  logic        blank,
  output logic [3:0]  digit_data,
  output logic [3:0]  anode_n,
  output logic        frame_done
);
  logic [DIV_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      display_reg, pend_reg;
  logic             pending, tick, wrap, accept, lit;
  assign tick = cnt == DIV_W'(TICK_MAX);
  assign wrap = tick && idx == 2'd3;
  assign load_ready = !pending;
  assign accept = load_valid && load_ready;
`ifdef SEVEN_SEG_SCAN_LZB_EN
  assign lit = idx == 2'd0 || (display_reg >> {idx, 2'b00}) != 16'd0;
`else
  assign lit = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 2'd0;
      display_reg <= 16'd0;
      pend_reg    <= 16'd0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      digit_data  <= 4'd0;
      anode_n     <= 4'b1110;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      idx        <= tick ? idx + 2'd1 : idx;
      if (wrap && pending) display_reg <= pend_reg;
      if (accept) pend_reg <= load_value;
      pending    <= accept || (pending && !wrap);
      frame_done <= wrap;
      digit_data <= display_reg[{idx, 2'b00} +: 4];
      anode_n    <= (blank || !lit) ? 4'b1111 : ~(4'b0001 << idx);
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: random and directed stimulus against a cycle-count-based reference model
module tb_seven_seg_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_value = 16'd0;
  logic        load_ready;
  logic        blank = 1'b0;
  logic [3:0]  digit_data;
  logic [3:0]  anode_n;
  logic        frame_done;
  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  logic [15:0] disp = 16'd0, pend = 16'd0;
  bit          pnd = 1'b0;
  logic [3:0]  e_an, e_dg;
  bit          e_fd;
  seven_seg_scan #(.TICK_MAX(3), .DIV_W(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready), .blank(blank), .digit_data(digit_data),
    .anode_n(anode_n), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit lv, input logic [15:0] v, input bit b);
    int k;
    bit lit, acc;
    @(negedge clk);
    rst = r; load_valid = lv; load_value = v; blank = b;
    if (r) begin
      disp = 0; pend = 0; pnd = 0; n = 0; e_an = 4'b1110; e_dg = 0; e_fd = 0;
    end else begin
      k = (n / 4) % 4;
      e_dg = 4'((disp >> (4 * k)) & 16'hf);
      lit = (k == 0) || ((disp >> (4 * k)) != 0);
`ifndef SEVEN_SEG_SCAN_LZB_EN
      lit = 1'b1;
`endif
      e_an = (b || !lit) ? 4'b1111 : ~(4'b0001 << k);
      e_fd = (n % 16) == 15;
      acc = lv && !pnd;
      if (e_fd && pnd) begin disp = pend; pnd = 0; end
      if (acc) begin pend = v; pnd = 1; end
      n++;
    end
    @(posedge clk);
    #1;
    check("anode_n", 16'(anode_n), 16'(e_an));
    check("digit_data", 16'(digit_data), 16'(e_dg));
    check("frame_done", 16'(frame_done), 16'(e_fd));
    check("load_ready", 16'(load_ready), 16'(!pnd));
  endtask
  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(0, 0, 16'd0, 0);
  endtask
  initial begin
    step(1, 0, 0, 0);
    idle(40);
    step(0, 1, 16'h1A3F, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 16'h5555, 0);
    idle(40);
    step(0, 1, 16'hBEEF, 0);
    idle(3);
    step(1, 0, 0, 0);
    idle(40);
    while (n % 16 != 15) step(0, 0, 0, 0);
    step(0, 1, 16'h2468, 0);
    idle(40);
    step(0, 1, 16'h0042, 0);
    idle(40);
    step(0, 1, 16'h0000, 0);
    idle(40);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      v = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, v, $urandom_range(0, 7) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
